fp_div_seq: RTL
===============

FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: clk input 1 rising-edge clock; rst input 1 asynchronous active-low reset (rst=0 resets).
REQ-002 SHALL have: a input 32 dividend (IEEE 754 single); b input 32 divisor; rnd input 3 rounding mode; start input 1 request.
REQ-003 SHALL have: z output 32 quotient; status output 8 flags; busy output 1 operation in progress; done output 1 result-valid pulse.
REQ-004 SHALL encode rnd as: 0 IEEE_near (ties-even), 1 IEEE_zero, 2 IEEE_pinf, 3 IEEE_ninf, 4 near_up (ties toward +inf), 5 away_zero; 6/7 treated as 0.
REQ-005 SHALL encode status as: [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge, [5] inexact, [7:6] always 0.

Function
REQ-006 SHALL implement FSM IDLE -> DIV -> RND -> DONE -> IDLE.
REQ-007 SHALL accept start only in IDLE, latching a, b and rnd at that edge. start in any other state SHALL be ignored.
REQ-008 SHALL set sign = a[31]^b[31] for all non-NaN results.
REQ-009 SHALL flush denormal operands (exp=0) to signed zero, with no tiny flag for inputs.
REQ-010 SHALL handle special cases by skipping DIV (IDLE -> RND -> DONE) as follows:
- Any NaN, 0/0 or inf/inf -> z=0x7FC00000, nan=1.
- x/0 with x finite nonzero, or inf/finite -> signed inf, inf=1.
- 0/x with x nonzero, or finite/inf -> signed zero, zero=1.
REQ-011 SHALL, in DIV, run restoring division of {1,ma} by {1,mb}, one quotient bit per cycle for exactly 26 cycles, giving q[25:0] = floor(ma*2^25/mb) and a remainder.
REQ-012 SHALL normalize the quotient:
- q[25]=1: mantissa=q[25:2], guard=q[1], sticky=q[0]|(rem!=0), exp=ea-eb+127.
- q[25]=0: mantissa=q[24:1], guard=q[0], sticky=(rem!=0), exp=ea-eb+126.
REQ-013 SHALL compute exponents in a 10-bit signed width (range -127..381); no truncation before overflow/underflow checks.
REQ-014 SHALL round in RND per rnd using guard/sticky/sign. Mantissa carry-out SHALL increment exp. inexact = guard|sticky.
REQ-015 SHALL, on overflow (post-round exp>254), set huge=1 and inexact=1. Result: signed inf (inf=1) for modes 0, 4, 5 and for 2 (positive)/3 (negative); otherwise signed max normal 0x7F7FFFFF magnitude.
REQ-016 SHALL, on underflow (post-round exp<1), set tiny=1 and inexact=1. Result: signed min normal 0x00800000 magnitude for mode 5, 2 (positive) or 3 (negative); otherwise signed zero (zero=1).
REQ-017 SHALL keep busy=1 in DIV and RND, and 0 otherwise.
REQ-018 SHALL update z/status at the RND->DONE edge. done SHALL be 1 for exactly the one cycle in DONE. z/status SHALL hold until the next update.
REQ-019 SHALL give latency start-edge to done-high of 28 cycles (normal path) and 2 cycles (special path).
REQ-020 SHALL accept a start asserted in the DONE cycle on the following IDLE cycle only (no back-to-back overlap).

Reset
REQ-021 SHALL, while rst=0 (asynchronously), force state=IDLE, z=0, status=0, busy=0, done=0, and clear the divider counter and registers.
REQ-022 SHALL abort any operation on mid-operation reset, without emitting done for it. The first start after rst=1 SHALL be processed normally.

Verification
REQ-023 a=0x40C00000, b=0x40000000, rnd=0, start -> done 28 cycles later, z=0x40400000, status=0x00.
REQ-024 a=0x3F800000, b=0x40400000: rnd=0 -> z=0x3EAAAAAB, status=0x20; rnd=1 -> z=0x3EAAAAAA, status=0x20.
REQ-025 Special cases, each with done 2 cycles after start:
- a=0x3F800000, b=0x00000000 -> z=0x7F800000, status=0x02.
- a=0, b=0 -> z=0x7FC00000, status=0x04.
- a=0x00000001, b=0x3F800000 -> z=0x00000000, status=0x01.
REQ-026 Range limits:
- a=0x7F000000, b=0x3E800000, rnd=0 -> z=0x7F800000, status=0x32; rnd=1 -> z=0x7F7FFFFF, status=0x30.
- a=0x00800000, b=0x40000000, rnd=0 -> z=0x00000000, status=0x29.
REQ-027 Reset and start protocol:
- rst pulsed low 10 cycles into a division -> busy=0, done never pulses, z=0; next start yields the correct result.
- start held high throughout a division -> exactly one result per IDLE acceptance.

Source files
------------

// File: rtl/fp_div_seq.sv
// Sequential IEEE 754 single-precision divider.
// The mantissa quotient is formed by restoring division at one bit per clock.
// Special operands skip the divider and go straight to the rounding stage.
module fp_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rnd,
    input  logic        start,
    output logic [31:0] z,
    output logic [7:0]  status,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_RND  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [31:0]        a_r, b_r;
    logic [2:0]         rnd_r;
    logic [25:0]        rem_r, q_r;
    logic [4:0]         cnt_r;
    logic signed [9:0]  exp_base_r;
    logic [31:0]        z_r;
    logic [7:0]         status_r;
    logic               busy_r, done_r;

    logic               accept_s;
    logic [25:0]        divisor_s;
    logic [25:0]        diff_s;
    logic [31:0]        res_z_s;
    logic [7:0]         res_st_s;

    // Operands with a zero (denormal-flushed), infinite or NaN field bypass the divider.
    function automatic logic is_special(input logic [31:0] x, input logic [31:0] y);
        return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
               (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
    endfunction

    // Result of a special-operand division: {status, z}.
    function automatic logic [39:0] special_result(input logic [31:0] x, input logic [31:0] y);
        logic xz, yz, xi, yi, xn, yn, sg;
        xz = (x[30:23] == 8'h00);
        yz = (y[30:23] == 8'h00);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        sg = x[31] ^ y[31];
        if (xn || yn || (xz && yz) || (xi && yi)) begin
            return {8'h04, 32'h7FC00000};
        end else if (yz || xi) begin
            return {8'h02, sg, 8'hFF, 23'd0};
        end else begin
            return {8'h01, sg, 31'd0};
        end
    endfunction

    // Rounding increment decision from mode, sign, lsb, guard and sticky.
    function automatic logic round_up(input logic [2:0] mode, input logic sg,
                                      input logic lsb, input logic g, input logic s);
        case (mode)
            3'd0:    return g & (s | lsb);
            3'd1:    return 1'b0;
            3'd2:    return ~sg & (g | s);
            3'd3:    return sg & (g | s);
            3'd4:    return g & (s | ~sg);
            3'd5:    return g | s;
            default: return g & (s | lsb);
        endcase
    endfunction

    assign accept_s  = (state_r == S_IDLE) && start;
    assign divisor_s = {2'b00, 1'b1, b_r[22:0]};
    assign diff_s    = rem_r - divisor_s;

    // Next-state logic for the IDLE -> DIV -> RND -> DONE sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = is_special(a, b) ? S_RND : S_DIV;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_DIV: begin
                if (cnt_r == 5'd25) begin
                    state_s = S_RND;
                end else begin
                    state_s = S_DIV;
                end
            end
            S_RND:   state_s = S_DONE;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture and restoring division, one quotient bit per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r        <= 32'd0;
            b_r        <= 32'd0;
            rnd_r      <= 3'd0;
            rem_r      <= 26'd0;
            q_r        <= 26'd0;
            cnt_r      <= 5'd0;
            exp_base_r <= 10'sd0;
        end else if (accept_s) begin
            a_r        <= a;
            b_r        <= b;
            rnd_r      <= (rnd > 3'd5) ? 3'd0 : rnd;
            rem_r      <= {2'b00, 1'b1, a[22:0]};
            q_r        <= 26'd0;
            cnt_r      <= 5'd0;
            exp_base_r <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
        end else if (state_r == S_DIV) begin
            if (rem_r >= divisor_s) begin
                q_r   <= {q_r[24:0], 1'b1};
                rem_r <= {diff_s[24:0], 1'b0};
            end else begin
                q_r   <= {q_r[24:0], 1'b0};
                rem_r <= {rem_r[24:0], 1'b0};
            end
            cnt_r <= cnt_r + 5'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Normalize, round and range-check the quotient into the final word and flags.
    always_comb begin
        logic [23:0]       mant_v;
        logic              g_v, s_v, sg_v, up_v, to_inf_v, to_min_v;
        logic signed [9:0] exp_v;
        logic [24:0]       sum_v;
        logic [22:0]       frac_v;
        logic [39:0]       sp_v;
        res_z_s  = 32'd0;
        res_st_s = 8'd0;
        sg_v     = a_r[31] ^ b_r[31];
        sp_v     = special_result(a_r, b_r);
        if (q_r[25]) begin
            mant_v = q_r[25:2];
            g_v    = q_r[1];
            s_v    = q_r[0] | (rem_r != 26'd0);
            exp_v  = exp_base_r;
        end else begin
            mant_v = q_r[24:1];
            g_v    = q_r[0];
            s_v    = (rem_r != 26'd0);
            exp_v  = exp_base_r - 10'sd1;
        end
        up_v  = round_up(rnd_r, sg_v, mant_v[0], g_v, s_v);
        sum_v = {1'b0, mant_v} + {24'd0, up_v};
        if (sum_v[24]) begin
            frac_v = sum_v[23:1];
            exp_v  = exp_v + 10'sd1;
        end else begin
            frac_v = sum_v[22:0];
        end
        to_inf_v = (rnd_r == 3'd0) || (rnd_r == 3'd4) || (rnd_r == 3'd5) ||
                   ((rnd_r == 3'd2) && !sg_v) || ((rnd_r == 3'd3) && sg_v);
        to_min_v = (rnd_r == 3'd5) || ((rnd_r == 3'd2) && !sg_v) || ((rnd_r == 3'd3) && sg_v);
        if (is_special(a_r, b_r)) begin
            res_st_s = sp_v[39:32];
            res_z_s  = sp_v[31:0];
        end else if (exp_v > 10'sd254) begin
            res_st_s = to_inf_v ? 8'h32 : 8'h30;
            res_z_s  = to_inf_v ? {sg_v, 8'hFF, 23'd0} : {sg_v, 31'h7F7FFFFF};
        end else if (exp_v < 10'sd1) begin
            res_st_s = to_min_v ? 8'h28 : 8'h29;
            res_z_s  = to_min_v ? {sg_v, 31'h00800000} : {sg_v, 31'd0};
        end else begin
            res_st_s = {2'b00, (g_v | s_v), 5'd0};
            res_z_s  = {sg_v, exp_v[7:0], frac_v};
        end
    end

    // Registered outputs: result captured on leaving RND, busy/done follow the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_r      <= 32'd0;
            status_r <= 8'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            if (state_r == S_RND) begin
                z_r      <= res_z_s;
                status_r <= res_st_s;
            end else begin
                z_r      <= z_r;
                status_r <= status_r;
            end
            busy_r <= (state_s == S_DIV) || (state_s == S_RND);
            done_r <= (state_s == S_DONE);
        end
    end

    assign z      = z_r;
    assign status = status_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule
